// File: rtl/hconv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// hconv_seq_ctrl
//
// Sequencer for a free-running horizontal Gaussian convolver. It takes a
// valid/ready pixel stream from the frame reader and counts the columns and
// rows of the frame. It feeds the convolver pixel input, and it drives the
// buffer-clear and the left-edge row-end mask. It also tags the convolver
// output with a valid strobe that is delayed by the fixed pipeline latency.
//
// Frame sequence: IDLE -> CLEAR -> (ROW -> HBLK) x IM_H -> DRAIN -> IDLE.
//
// Parameters
//   IM_W  pixels per row (must equal the convolver row length)
//   IM_H  rows per frame
//   HKER  kernel taps; the row-end mask is HKER-1 bits wide
//   LAT   convolver latency, from c_hin sample to the matching c_hout
//   HBLK  zero-filled flush cycles inserted after every row
//
// Ports
//   clk        rising-edge clock
//   hres       synchronous active-high reset
//   start      single-cycle pulse; opens a frame when idle, ignored otherwise
//   s_data     upstream pixel
//   s_valid    upstream pixel valid
//   s_ready    a pixel is consumed this cycle (ROW state)
//   c_hin      convolver pixel input (zero outside accepted ROW cycles)
//   c_hclr     convolver buffer clear (CLEAR state only)
//   c_hrowend  convolver row-end mask, bit j set when col > j in ROW
//   c_hout     convolver output
//   m_data     filtered pixel (c_hout passed through)
//   m_valid    m_data corresponds to an accepted pixel
//   busy       state is not IDLE
//   frame_done one-cycle pulse on return to IDLE at the end of a frame
//   underrun   sticky; set by a ROW cycle without s_valid, cleared by
//              hres or an accepted start
// ---------------------------------------------------------------------------
module hconv_seq_ctrl #(
    parameter int IM_W = 520,
    parameter int IM_H = 520,
    parameter int HKER = 3,
    parameter int LAT  = 1043,
    parameter int HBLK = 4
) (
    input  logic            clk,
    input  logic            hres,
    input  logic            start,
    input  logic [15:0]     s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [15:0]     c_hin,
    output logic            c_hclr,
    output logic [HKER-2:0] c_hrowend,
    input  logic [15:0]     c_hout,
    output logic [15:0]     m_data,
    output logic            m_valid,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun
);

    localparam int CW   = (IM_W > 1) ? $clog2(IM_W) : 1;
    localparam int RW   = (IM_H > 1) ? $clog2(IM_H) : 1;
    localparam int TMAX = (LAT > HBLK) ? LAT : HBLK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] LAST_COL  = CW'(IM_W - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(IM_H - 1);
    localparam logic [TW-1:0] LAST_BLK  = TW'(HBLK - 1);
    localparam logic [TW-1:0] LAST_DRN  = TW'(LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ROW,
        ST_HBLK,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    // One timer serves both the HBLK gap and the DRAIN period; the two
    // never overlap and the timer is re-zeroed on every entry.
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic [LAT-1:0]   vld_sr_q, vld_sr_d;
    logic             vld_in;

    // -----------------------------------------------------------------------
    // State register and datapath flops
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (hres) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            tmr_q      <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            vld_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tmr_q      <= tmr_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            vld_sr_q   <= vld_sr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        tmr_d      = tmr_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    col_d      = '0;
                    row_d      = '0;
                    tmr_d      = '0;
                    underrun_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                state_d = ST_ROW;
                col_d   = '0;
            end

            ST_ROW: begin
                // The convolver cannot stall, so a missing pixel still
                // consumes its column slot as a zero.
                if (!s_valid) begin
                    underrun_d = 1'b1;
                end
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_HBLK;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            ST_HBLK: begin
                if (tmr_q == LAST_BLK) begin
                    tmr_d = '0;
                    if (row_q != LAST_ROW) begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_ROW;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (tmr_q == LAST_DRN) begin
                    tmr_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Valid tagging: accepted pixels ride a LAT-deep shift register so that
    // the tail lines up with the matching convolver output.
    // -----------------------------------------------------------------------
    always_comb begin
        vld_in = (state_q == ST_ROW) && s_valid;
        if (LAT > 1) begin
            vld_sr_d = {vld_sr_q[LAT-2:0], vld_in};
        end else begin
            vld_sr_d = LAT'(vld_in);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        s_ready    = (state_q == ST_ROW);
        c_hin      = ((state_q == ST_ROW) && s_valid) ? s_data : '0;
        c_hclr     = (state_q == ST_CLEAR);
        busy       = (state_q != ST_IDLE);
        m_valid    = vld_sr_q[LAT-1];
        m_data     = c_hout;
        frame_done = done_q;
        underrun   = underrun_q;

        // Tap j reaches back j+1 pixels; it is only meaningful once that many
        // pixels of the current row have entered, which zero-pads the left edge.
        c_hrowend = '0;
        for (int unsigned j = 0; j < HKER - 1; j++) begin
            c_hrowend[j] = (state_q == ST_ROW) && (32'(col_q) > j);
        end
    end

endmodule

// File: tb/tb_hconv_seq_ctrl.sv
module tb_hconv_seq_ctrl;

    localparam int IM_W = 8;
    localparam int IM_H = 2;
    localparam int HKER = 3;
    localparam int LAT  = 24;
    localparam int HBLK = 4;

    logic            clk = 1'b0;
    logic            hres = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [15:0]     c_hin;
    logic            c_hclr;
    logic [HKER-2:0] c_hrowend;
    logic [15:0]     c_hout;
    logic [15:0]     m_data;
    logic            m_valid;
    logic            busy;
    logic            frame_done;
    logic            underrun;

    hconv_seq_ctrl #(
        .IM_W(IM_W),
        .IM_H(IM_H),
        .HKER(HKER),
        .LAT (LAT),
        .HBLK(HBLK)
    ) dut (
        .clk       (clk),
        .hres      (hres),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .c_hin     (c_hin),
        .c_hclr    (c_hclr),
        .c_hrowend (c_hrowend),
        .c_hout    (c_hout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- convolver model: 1-2-1 kernel, masked taps, LAT pipe
    logic [15:0] h1 = '0;
    logic [15:0] h2 = '0;
    logic [15:0] pipe [LAT] = '{default: 16'h0};

    function automatic logic [15:0] conv(input logic [15:0] x, a, b, input logic [1:0] m);
        int s;
        s = int'(x) + (m[0] ? 2 * int'(a) : 0) + (m[1] ? int'(b) : 0);
        return 16'(s >> 2);
    endfunction

    always @(posedge clk) begin
        if (c_hclr) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= c_hin;
            h2 <= h1;
        end
        pipe[0] <= conv(c_hin, h1, h2, c_hrowend);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign c_hout = pipe[LAT-1];

    // ---------------- reference and scoreboard
    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int rowpix [IM_W];
    function automatic int gauss_ref(input int col);
        int s;
        s = rowpix[col];
        if (col >= 1) s += 2 * rowpix[col-1];
        if (col >= 2) s += rowpix[col-2];
        return s >> 2;
    endfunction

    typedef enum {P_IDLE, P_CLEAR, P_ROW, P_BLK, P_DRAIN} phase_t;

    bit mon_en    = 1'b0;
    int mv_count  = 0;
    int accepted  = 0;
    bit exp_under = 1'b0;
    bit seq_mode  = 1'b0;
    int seq_pix   = 1;

    // monitor: pops the expected entry whenever the DUT presents m_valid
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid) begin
                mv_count++;
                if (sb.size() == 0) begin
                    chk("m_valid_unexpected", int'(m_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("m_valid_cycle", cyc, e.due);
                    chk("m_data", int'(m_data), int'(e.data));
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("m_valid_at_due", int'(m_valid), 1);
                void'(sb.pop_front());
            end
        end
    end

    // one clock cycle: drive at posedge+1, check at negedge
    task automatic tick(input phase_t ph, input int col, input bit sv,
                        input bit st, input bit rst, input bit done);
        logic [HKER-2:0] exp_re;
        int              exp_hin;
        @(posedge clk);
        #1;
        hres    = rst;
        start   = st;
        s_valid = sv;
        s_data  = seq_mode ? 16'(seq_pix) : 16'($urandom);
        exp_hin = (ph == P_ROW && sv) ? int'(s_data) : 0;
        if (ph == P_ROW) begin
            rowpix[col] = exp_hin;
            if (sv && !rst) begin
                sb.push_back('{due: cyc + LAT, data: 16'(gauss_ref(col))});
                accepted++;
                seq_pix++;
            end
        end
        for (int j = 0; j < HKER - 1; j++) exp_re[j] = (ph == P_ROW) && (col > j);
        @(negedge clk);
        chk("s_ready",    int'(s_ready),    int'(ph == P_ROW));
        chk("c_hclr",     int'(c_hclr),     int'(ph == P_CLEAR));
        chk("busy",       int'(busy),       int'(ph != P_IDLE));
        chk("c_hin",      int'(c_hin),      exp_hin);
        chk("c_hrowend",  int'(c_hrowend),  int'(exp_re));
        chk("frame_done", int'(frame_done), int'(done));
        chk("underrun",   int'(underrun),   int'(exp_under));
        #1;
        if (rst) begin
            sb.delete();
            exp_under = 1'b0;
        end else begin
            if (ph == P_ROW && !sv) exp_under = 1'b1;
            if (ph == P_IDLE && st) exp_under = 1'b0;
        end
    endtask

    // one frame; und_*: forced missing pixel, rst_*: hres point (-1 = none)
    task automatic run_frame(input int und_r, input int und_c, input int vprob,
                             input bit pulse_busy, input int rst_r, input int rst_c);
        int mv0;
        bit sv;
        bit rst;
        mv0      = mv_count;
        accepted = 0;
        tick(P_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(P_CLEAR, 0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < IM_H; r++) begin
            for (int c = 0; c < IM_W; c++) begin
                sv  = (r == und_r && c == und_c) ? 1'b0 : (int'($urandom_range(99)) < vprob);
                rst = (r == rst_r && c == rst_c);
                tick(P_ROW, c, sv, pulse_busy && r == 0 && c == 2, rst, 1'b0);
                if (rst) begin
                    tick(P_IDLE, 0, 1'($urandom), 1'b0, 1'b0, 1'b0);
                    chk("m_valid_after_hres", int'(m_valid), 0);
                    for (int i = 0; i < LAT + 4; i++)
                        tick(P_IDLE, 0, 1'($urandom), 1'b0, 1'b0, 1'b0);
                    return;
                end
            end
            for (int b = 0; b < HBLK; b++)
                tick(P_BLK, 0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        for (int d = 0; d < LAT; d++)
            tick(P_DRAIN, 0, 1'($urandom), pulse_busy && d == 5, 1'b0, 1'b0);
        tick(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("valid_pulses", mv_count - mv0, accepted);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        hres = 1'b1;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        tick(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("m_valid_reset", int'(m_valid), 0);

        // pixels 1..16, s_valid held high
        seq_mode = 1'b1;
        seq_pix  = 1;
        run_frame(-1, -1, 100, 1'b0, -1, -1);
        seq_mode = 1'b0;

        // missing pixel at row 0, col 3
        run_frame(0, 3, 100, 1'b0, -1, -1);

        // start pulses while busy are ignored
        run_frame(-1, -1, 100, 1'b1, -1, -1);

        // hres mid-row at row 1, col 4
        run_frame(-1, -1, 100, 1'b0, 1, 4);

        // start coinciding with hres: hres wins
        tick(P_IDLE, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(P_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized back-to-back frames with sporadic underruns
        for (int k = 0; k < 6; k++)
            run_frame(-1, -1, 75, 1'(k), -1, -1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
